// File: rtl/pl_tx_msg_sender.sv
// Protocol-layer transmit engine: buffers a message, drives the PHY packet/payload handshake, retries on busy line.
// Optional watchdog on each attempt is enabled with `define PL_TX_WATCHDOG_EN.
module pl_tx_msg_sender #(
  parameter int BUF_DEPTH   = 30,
  parameter int MAX_RETRY   = 2,
  parameter int RETRY_GAP   = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       msg_start,
  input  logic [2:0] msg_type,
  input  logic [4:0] msg_len,
  output logic       tx_busy,
  output logic       tx_status_en,
  output logic [1:0] tx_status,
  output logic       pl2phy_tx_packet_en,
  output logic [2:0] pl2phy_tx_packet_type,
  input  logic       phy2pl_tx_packet_done,
  input  logic       phy2pl_tx_packet_result,
  output logic       pl2phy_tx_payload_en,
  output logic [7:0] pl2phy_tx_payload,
  output logic       pl2phy_tx_payload_last,
  input  logic       phy2pl_tx_payload_done
);
  localparam int PTR_W = $clog2(BUF_DEPTH + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);

  typedef enum logic [2:0] {IDLE, REQ, STREAM, WAIT_DONE, GAP, REPORT} state_t;
  typedef enum logic [1:0] {ST_SENT, ST_RETRY, ST_BAD, ST_WDOG} status_t;
  typedef struct packed {
    logic [2:0] ptype;
    logic [4:0] len;
  } req_t;

  state_t           state, state_nxt;
  status_t          status_q, status_nxt;
  req_t             req_q;
  logic [7:0]       buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [RTY_W-1:0] retry_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             req_bad, is_last, can_retry, pkt_done, retry_inc, wdog_hit, wr_ok;

  always_comb begin
    req_bad = 1'b0;
    case (msg_type)
      3'd7:       req_bad = 1'b1;
      3'd5, 3'd6: req_bad = (msg_len != 5'd0);
      default:    req_bad = (msg_len == 5'd0) || (32'(msg_len) > 32'(wr_ptr));
    endcase
  end

  assign is_last   = (32'(rd_ptr) + 32'd1 == 32'(req_q.len));
  assign can_retry = (32'(retry_cnt) < 32'(MAX_RETRY));
  // PHY completion is only meaningful once the request has gone out
  assign pkt_done  = phy2pl_tx_packet_done && (state == STREAM || state == WAIT_DONE);
  assign wr_ok     = wr_en && (state == IDLE) && (32'(wr_ptr) != 32'(BUF_DEPTH));

`ifdef PL_TX_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            active;

  assign active   = (state == REQ) || (state == STREAM) || (state == WAIT_DONE);
  assign wdog_hit = active && (32'(wdog_cnt) == 32'(WDOG_CYCLES - 1));

  // restarts for every attempt, so a retry gets a full window
  always_ff @(posedge clk) begin
    if (rst || !active) wdog_cnt <= '0;
    else                wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    retry_inc  = 1'b0;
    case (state)
      IDLE: if (msg_start) begin
        state_nxt  = req_bad ? REPORT : REQ;
        status_nxt = req_bad ? ST_BAD : ST_SENT;
      end
      REQ:     state_nxt = (req_q.ptype >= 3'd5) ? WAIT_DONE : STREAM;
      STREAM:  if (phy2pl_tx_payload_done && is_last) state_nxt = WAIT_DONE;
      GAP:     if (32'(gap_cnt) == 32'(RETRY_GAP - 1)) state_nxt = REQ;
      REPORT:  state_nxt = IDLE;
      default: ;
    endcase
    if (pkt_done) begin
      if (phy2pl_tx_packet_result) begin
        state_nxt  = REPORT;
        status_nxt = ST_SENT;
      end else if (can_retry) begin
        state_nxt = GAP;
        retry_inc = 1'b1;
      end else begin
        state_nxt  = REPORT;
        status_nxt = ST_RETRY;
      end
    end else if (wdog_hit) begin
      state_nxt  = REPORT;
      status_nxt = ST_WDOG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      status_q  <= ST_SENT;
      req_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
      if (state == IDLE && msg_start && !req_bad) req_q <= '{ptype: msg_type, len: msg_len};
      if (state == REPORT) wr_ptr <= '0;
      else if (wr_ok)      wr_ptr <= wr_ptr + 1'b1;
      if (state == REQ) rd_ptr <= '0;
      else if (state == STREAM && phy2pl_tx_payload_done && !is_last && !pkt_done)
        rd_ptr <= rd_ptr + 1'b1;
      if (state == REPORT) retry_cnt <= '0;
      else if (retry_inc)  retry_cnt <= retry_cnt + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) buf_mem[wr_ptr] <= wr_data;
  end

  assign tx_busy                = (state != IDLE);
  assign tx_status_en           = (state == REPORT);
  assign tx_status              = tx_status_en ? status_q : ST_SENT;
  assign pl2phy_tx_packet_en    = (state == REQ);
  assign pl2phy_tx_packet_type  = req_q.ptype;
  assign pl2phy_tx_payload_en   = (state == STREAM);
  assign pl2phy_tx_payload      = pl2phy_tx_payload_en ? buf_mem[rd_ptr] : 8'h00;
  assign pl2phy_tx_payload_last = pl2phy_tx_payload_en && is_last;
endmodule

// File: tb/tb_pl_tx_msg_sender.sv
// Directed bench for pl_tx_msg_sender: send, retry, exhaustion, bad requests, full buffer, reset mid-stream.
module tb_pl_tx_msg_sender;
  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_en = 1'b0, msg_start = 1'b0;
  logic [7:0] wr_data = '0;
  logic [2:0] msg_type = '0;
  logic [4:0] msg_len = '0;
  logic       tx_busy, tx_status_en;
  logic [1:0] tx_status;
  logic       pl2phy_tx_packet_en;
  logic [2:0] pl2phy_tx_packet_type;
  logic       phy2pl_tx_packet_done = 1'b0, phy2pl_tx_packet_result = 1'b0;
  logic       pl2phy_tx_payload_en, pl2phy_tx_payload_last;
  logic [7:0] pl2phy_tx_payload;
  logic       phy2pl_tx_payload_done = 1'b0;

  int total = 0, bad = 0;

  pl_tx_msg_sender #(.WDOG_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .msg_start(msg_start), .msg_type(msg_type), .msg_len(msg_len),
    .tx_busy(tx_busy), .tx_status_en(tx_status_en), .tx_status(tx_status),
    .pl2phy_tx_packet_en(pl2phy_tx_packet_en), .pl2phy_tx_packet_type(pl2phy_tx_packet_type),
    .phy2pl_tx_packet_done(phy2pl_tx_packet_done), .phy2pl_tx_packet_result(phy2pl_tx_packet_result),
    .pl2phy_tx_payload_en(pl2phy_tx_payload_en), .pl2phy_tx_payload(pl2phy_tx_payload),
    .pl2phy_tx_payload_last(pl2phy_tx_payload_last), .phy2pl_tx_payload_done(phy2pl_tx_payload_done)
  );

  always #5 clk = ~clk;

  // observation log, sampled mid-cycle
  int         cyc = 0, n_pkt = 0, n_stat = 0, n_pl_cyc = 0;
  logic [7:0] bytes[$];
  logic       lasts[$];
  int         pkt_cyc[$], done_cyc[$];
  logic [2:0] pkt_type_seen;

  always @(negedge clk) begin
    cyc++;
    if (pl2phy_tx_packet_en) begin
      n_pkt++;
      pkt_cyc.push_back(cyc);
      pkt_type_seen = pl2phy_tx_packet_type;
    end
    if (pl2phy_tx_payload_en) n_pl_cyc++;
    if (pl2phy_tx_payload_en && phy2pl_tx_payload_done) begin
      bytes.push_back(pl2phy_tx_payload);
      lasts.push_back(pl2phy_tx_payload_last);
    end
    if (phy2pl_tx_packet_done) done_cyc.push_back(cyc);
    if (tx_status_en) n_stat++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bytes.delete(); lasts.delete(); pkt_cyc.delete(); done_cyc.delete();
    n_pkt = 0; n_stat = 0; n_pl_cyc = 0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b; step(); wr_en = 1'b0;
  endtask

  task automatic wr_msg4();
    wr_byte(8'h41); wr_byte(8'h10); wr_byte(8'h00); wr_byte(8'h00);
  endtask

  task automatic start(input logic [2:0] t, input logic [4:0] l);
    msg_type = t; msg_len = l; msg_start = 1'b1; step(); msg_start = 1'b0;
  endtask

  // one PHY attempt: wait for the request, ack bytes (slow: one cycle later; fast: every cycle), then finish
  task automatic phy_attempt(input logic res, input logic fast);
    int   g;
    logic t;
    g = 0;
    while (!pl2phy_tx_packet_en && g < 100) begin step(); g++; end
    chk("pkt_en_seen", pl2phy_tx_packet_en, 1);
    step();
    g = 0; t = 1'b0;
    while (pl2phy_tx_payload_en && g < 200) begin
      phy2pl_tx_payload_done = fast | t;
      t = ~t;
      step(); g++;
    end
    chk("stream_bounded", g < 200, 1);
    phy2pl_tx_payload_done = 1'b0;
    phy2pl_tx_packet_done = 1'b1; phy2pl_tx_packet_result = res;
    step();
    phy2pl_tx_packet_done = 1'b0; phy2pl_tx_packet_result = 1'b0;
  endtask

  function automatic logic [31:0] pack4(input int base);
    if (bytes.size() < base + 4) return 32'hdeadbeef;
    return {bytes[base], bytes[base+1], bytes[base+2], bytes[base+3]};
  endfunction

  function automatic logic [3:0] last4();
    if (lasts.size() != 4) return 4'hf;
    return {lasts[0], lasts[1], lasts[2], lasts[3]};
  endfunction

  function automatic logic [17:0] outs();
    return {tx_busy, tx_status_en, tx_status, pl2phy_tx_packet_en, pl2phy_tx_packet_type,
            pl2phy_tx_payload_en, pl2phy_tx_payload, pl2phy_tx_payload_last};
  endfunction

  initial begin
    int nl;
    // reset
    repeat (3) step();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    step();
    chk("idle_outs", outs(), 0);

    // basic send
    clr(); wr_msg4();
    start(3'd0, 5'd4);
    chk("lat_pkt_en", pl2phy_tx_packet_en, 1);
    chk("busy_after_start", tx_busy, 1);
    phy_attempt(1'b1, 1'b0);
    chk("t1_status_en", tx_status_en, 1);
    chk("t1_status", tx_status, 2'b00);
    step();
    chk("t1_busy_low", tx_busy, 0);
    chk("t1_bytes", pack4(0), 32'h41100000);
    chk("t1_lasts", last4(), 4'b0001);
    chk("t1_n_pkt", n_pkt, 1);
    chk("t1_n_stat", n_stat, 1);
    chk("t1_type", pkt_type_seen, 3'd0);

    // two busy-line failures then success
    clr(); wr_msg4();
    start(3'd0, 5'd4);
    phy_attempt(1'b0, 1'b0);
    chk("t2_gap_busy", tx_busy, 1);
    phy_attempt(1'b0, 1'b0);
    phy_attempt(1'b1, 1'b0);
    chk("t2_status_en", tx_status_en, 1);
    chk("t2_status", tx_status, 2'b00);
    step();
    chk("t2_n_pkt", n_pkt, 3);
    chk("t2_n_stat", n_stat, 1);
    chk("t2_gap1", (pkt_cyc.size() > 1 && done_cyc.size() > 0) ? pkt_cyc[1] - done_cyc[0] : -1, 17);
    chk("t2_gap2", (pkt_cyc.size() > 2 && done_cyc.size() > 1) ? pkt_cyc[2] - done_cyc[1] : -1, 17);
    chk("t2_bytes_a0", pack4(0), 32'h41100000);
    chk("t2_bytes_a1", pack4(4), 32'h41100000);
    chk("t2_bytes_a2", pack4(8), 32'h41100000);

    // retries exhausted
    clr(); wr_msg4();
    start(3'd0, 5'd4);
    phy_attempt(1'b0, 1'b0);
    phy_attempt(1'b0, 1'b0);
    phy_attempt(1'b0, 1'b0);
    chk("t3_status_en", tx_status_en, 1);
    chk("t3_status", tx_status, 2'b01);
    step();
    chk("t3_n_pkt", n_pkt, 3);
    // buffer emptied by the status pulse, so len 1 is now too long
    start(3'd0, 5'd1);
    chk("t3_wrptr_clr_status", {tx_status_en, tx_status}, 3'b110);
    step();

    // hard reset, no payload
    clr();
    start(3'd5, 5'd0);
    chk("t4_pkt_type", pl2phy_tx_packet_type, 3'd5);
    phy_attempt(1'b1, 1'b0);
    chk("t4_status", {tx_status_en, tx_status}, 3'b100);
    step();
    chk("t4_no_payload", n_pl_cyc, 0);

    // bad requests never reach the PHY
    clr(); wr_msg4();
    start(3'd0, 5'd0);
    chk("t5_len0", {tx_status_en, tx_status}, 3'b110);
    step();
    start(3'd7, 5'd0);
    chk("t5_type7", {tx_status_en, tx_status}, 3'b110);
    step();
    start(3'd6, 5'd2);
    chk("t5_cable_len", {tx_status_en, tx_status}, 3'b110);
    step();
    chk("t5_no_pkt", n_pkt, 0);
    chk("t5_n_stat", n_stat, 3);

    // full buffer: 31st write dropped
    clr();
    for (int i = 0; i < 31; i++) wr_byte(8'h80 + 8'(i));
    start(3'd0, 5'd31);
    chk("t6_len31_bad", {tx_status_en, tx_status}, 3'b110);
    step();
    for (int i = 0; i < 31; i++) wr_byte(8'h80 + 8'(i));
    start(3'd1, 5'd30);
    phy_attempt(1'b1, 1'b1);
    chk("t6_status", {tx_status_en, tx_status}, 3'b100);
    step();
    chk("t6_n_bytes", bytes.size(), 30);
    chk("t6_pl_cycles", n_pl_cyc, 30);
    chk("t6_first", bytes.size() > 0 ? bytes[0] : 8'hxx, 8'h80);
    chk("t6_lastbyte", bytes.size() == 30 ? bytes[29] : 8'hxx, 8'h9d);
    nl = 0;
    foreach (lasts[i]) nl += int'(lasts[i]);
    chk("t6_one_last", nl, 1);
    chk("t6_last_pos", lasts.size() == 30 ? lasts[29] : 1'bx, 1'b1);

`ifdef PL_TX_WATCHDOG_EN
    // silent PHY
    begin
      int k;
      clr(); wr_byte(8'h55);
      start(3'd0, 5'd1);
      k = 0;
      while (!tx_status_en && k < 300) begin step(); k++; end
      chk("wd_cycles", k, 100);
      chk("wd_status", tx_status, 2'b11);
      step();
    end
`endif

    // reset mid-stream
    clr(); wr_msg4();
    start(3'd0, 5'd4);
    step(); step();
    chk("t7_streaming", pl2phy_tx_payload_en, 1);
    rst = 1'b1;
    step();
    chk("t7_outs_zero", outs(), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("t7_no_status", n_stat, 0);
    chk("t7_n_pkt", n_pkt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pl_tx_msg_sender.md
Name: pl_tx_msg_sender

Overview:
- Protocol-layer transmit engine that drives the PHY's pl2phy_tx_* packet and payload handshake from the initiating side.
- Upper layer loads message bytes into an internal buffer, then issues a start request.
- Block requests the packet, streams the bytes one per PHY acknowledge, retries on a busy line, and reports one status per request.

Parameters:
- BUF_DEPTH, 30, byte buffer depth: 2 header bytes + 28 data bytes.
- MAX_RETRY, 2, retries after the first attempt when the PHY returns result=0.
- RETRY_GAP, 16, idle clk cycles between a failed attempt and the next retry.
- WDOG_CYCLES, 65535, watchdog limit in clk cycles (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  buffer write strobe
- wr_data  in  8  byte to append to the buffer
- msg_start  in  1  single-cycle start request
- msg_type  in  3  0 SOP, 1 SOP', 2 SOP'', 3 SOP'_dbg, 4 SOP''_dbg, 5 hard reset, 6 cable reset, 7 reserved
- msg_len  in  5  payload byte count
- tx_busy  out  1  high from accepted start until the status pulse
- tx_status_en  out  1  one-cycle status pulse
- tx_status  out  2  00 sent, 01 retries exhausted, 10 bad request, 11 watchdog
- pl2phy_tx_packet_en  out  1  one-cycle packet request
- pl2phy_tx_packet_type  out  3  type, held stable while tx_busy
- phy2pl_tx_packet_done  in  1  one-cycle completion from the PHY
- phy2pl_tx_packet_result  in  1  1 = transmitted, 0 = line not idle / aborted
- pl2phy_tx_payload_en  out  1  byte valid
- pl2phy_tx_payload  out  8  byte
- pl2phy_tx_payload_last  out  1  marks the final byte
- phy2pl_tx_payload_done  in  1  PHY consumed the current byte

Behaviour:
- Reset: rst sampled on posedge clk; all outputs 0, write pointer 0, retry count 0, FSM in IDLE. rst mid-packet drops payload_en the next cycle and emits no status.
- Buffer: wr_en appends at wr_ptr and increments it.
  - Writes are ignored when wr_ptr == BUF_DEPTH (no wrap) or while tx_busy.
  - wr_ptr clears to 0 on every status pulse.
- Request validation on msg_start in IDLE, flagged as bad request (10) if any of:
  - type 7;
  - types 0-4 with msg_len == 0 or msg_len > wr_ptr;
  - types 5-6 with msg_len != 0.
  - A bad request goes to REPORT directly; the PHY sees no activity.
- msg_start is ignored while tx_busy.
- FSM states: IDLE, REQ, STREAM, WAIT_DONE, GAP, REPORT.
  - IDLE: on a valid start, latch type and len; tx_busy=1; next state REQ.
  - REQ: pl2phy_tx_packet_en=1 for exactly one cycle. Next state is STREAM for types 0-4, WAIT_DONE for types 5-6. rd_ptr=0.
  - STREAM:
    - payload_en=1, payload=buf[rd_ptr], last=(rd_ptr==len-1).
    - On payload_done: rd_ptr++, and the new byte appears the next cycle.
    - On payload_done with last=1: payload_en=0 next cycle, go to WAIT_DONE.
    - payload_done with payload_en=0 is ignored.
  - packet_done is honoured in STREAM as well as WAIT_DONE; in STREAM it drops payload_en immediately (PHY abort).
  - On packet_done:
    - result=1 -> REPORT, status 00.
    - result=0 and retry_cnt < MAX_RETRY -> retry_cnt++, go to GAP.
    - result=0 otherwise -> REPORT, status 01.
  - GAP: count RETRY_GAP cycles, then go to REQ. The resend uses the same buffer contents.
  - REPORT: tx_status_en=1 for one cycle, tx_busy=0 next cycle, retry_cnt=0, go to IDLE.
- Latency: valid msg_start at cycle N -> packet_en at N+1 -> first payload_en at N+2.

Optional Feature:
- Macro PL_TX_WATCHDOG_EN.
- When defined: a counter runs from REQ until packet_done. Reaching WDOG_CYCLES forces payload_en=0 and goes to REPORT with status 11 (no retry).
- When undefined: no counter exists and status 11 is never produced.

Test Plan:
- Write 0x41,0x10,0x00,0x00; start type 0 len 4; PHY acks each byte one cycle later, then done result=1.
  -> 4 bytes in order, last only on 0x00, one packet_en, status 00 once, tx_busy low after it.
- Same message with the PHY returning result=0 twice, then 1.
  -> packet_en three times, each retry 16 idle cycles after the previous done, bytes identical each attempt, status 00.
- Result=0 on three consecutive attempts (MAX_RETRY=2).
  -> status 01 after the third done, wr_ptr back to 0.
- Start type 5 len 0 -> packet_en with type 5, no payload_en, status 00 on done. Start type 0 len 0, or type 7 -> no packet_en, status 10.
- Write 31 bytes -> 31st ignored. Start len 30 with payload_done asserted every cycle -> 30 bytes, payload_en deasserts the cycle after the last ack.
- With PL_TX_WATCHDOG_EN and WDOG_CYCLES=100, PHY never answers -> status 11 at cycle 100 after REQ. Assert rst mid-stream -> all outputs 0 next cycle, no status pulse.
